apb_master: RTL and testbench

- APB requester that drives the bus side of the I2C APB register slave: PSELx, PENABLE, PWRITE, PADDR and PWDATA; samples PRDATA and PREADY.
- Firmware-side logic pushes register read/write commands into a small request FIFO.
- The block issues each command as a compliant SETUP/ACCESS transfer and returns one response per command.
- The response carries read data, or an error if the slave stalls past a timeout.
- Intended targets are the I2C slave registers: prescale 0x20, address 0x40, status 0x60, transmit 0x80, command 0xC0.

---
 rtl/apb_master.sv | 197 +++++++++++++++++++
 tb/tb_apb_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: queues firmware register commands in a small FIFO and issues
// each one as a SETUP/ACCESS transfer, returning one response per command.
module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;

    state_e                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  busy_q, busy_d;

    logic [ENT_W-1:0]      head;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic                  timed_out;

    assign cmd_ready  = (count_q != CNT_FULL);
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem_q[rd_ptr_q];
    assign head_write = head[ENT_W-1];
    assign head_addr  = head[ENT_W-2 -: ADDR_WIDTH];
    assign head_wdata = head[DATA_WIDTH-1:0];

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    // Storage carries no reset; validity is tracked entirely by the pointers/count.
    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Abort on the edge that would be the TIMEOUT-th consecutive stalled ACCESS edge.
    assign timed_out = (TIMEOUT != 0) && !PREADY && (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (count_q != '0) begin
                    pop      = 1'b1;
                    pwrite_d = head_write;
                    paddr_d  = head_addr;
                    pwdata_d = head_wdata;
                    psel_d   = 1'b1;
                    wait_d   = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY || timed_out) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !PREADY;
                    rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
                    if (count_q != '0) begin
                        pop       = 1'b1;
                        pwrite_d  = head_write;
                        paddr_d   = head_addr;
                        pwdata_d  = head_wdata;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        wait_d    = '0;
                        state_d   = SETUP;
                    end else begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else if (TIMEOUT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // busy is registered from next-state values so it lines up with count_q/state_q.
    assign busy_d = (count_d != '0) || (state_d != IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a response scoreboard and a simple APB slave.
`timescale 1ns/100ps
module tb_apb_master;

    logic       PCLK, PRESETn;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_err, busy;
    logic [7:0] rsp_rdata;
    logic       PSELx, PENABLE, PWRITE, PREADY;
    logic [7:0] PADDR, PWDATA, PRDATA;

    typedef struct packed {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   rsp_seen = 0;
    int   psel_falls = 0;
    logic psel_prev = 1'b0;
    int   r0, f0;

    apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] rd, input logic err, input logic exp_acc);
        logic acc;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        acc = cmd_ready;
        chk("cmd_accept", {31'd0, acc}, {31'd0, exp_acc});
        if (acc) sb.push_back('{w: w, a: a, d: d, rd: rd, err: err});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
    endtask

    // Scoreboard side: responses are popped in order; APB phase checked at completion.
    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (rsp_valid) begin
                rsp_seen++;
                chk("rsp_expected", {31'd0, (sb.size() != 0)}, 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, mon_e.rd});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
                end
            end
            if (PSELx && PENABLE && PREADY && sb.size() != 0) begin
                chk("apb_paddr", {24'd0, PADDR}, {24'd0, sb[0].a});
                chk("apb_pwrite", {31'd0, PWRITE}, {31'd0, sb[0].w});
                chk("apb_pwdata", {24'd0, PWDATA}, {24'd0, sb[0].d});
            end
            if (psel_prev && !PSELx) psel_falls++;
            psel_prev = PSELx;
        end else begin
            psel_prev = 1'b0;
        end
    end

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PREADY = 1'b1; PRDATA = 8'h00;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_psel", {31'd0, PSELx}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_paddr", {24'd0, PADDR}, 32'd0);
        PRESETn = 1'b1;
        tick();

        // single write, PREADY tied high
        push(1'b1, 8'h20, 8'h04, 8'h00, 1'b0, 1'b1);
        chk("w1_psel_n0", {31'd0, PSELx}, 32'd0);
        chk("w1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("w1_psel_n1", {31'd0, PSELx}, 32'd1);
        chk("w1_penable_n1", {31'd0, PENABLE}, 32'd0);
        chk("w1_paddr", {24'd0, PADDR}, 32'h20);
        chk("w1_pwdata", {24'd0, PWDATA}, 32'h04);
        chk("w1_pwrite", {31'd0, PWRITE}, 32'd1);
        tick();
        chk("w1_penable_n2", {31'd0, PENABLE}, 32'd1);
        tick();
        chk("w1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("w1_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("w1_psel_drop", {31'd0, PSELx}, 32'd0);
        chk("w1_busy_idle", {31'd0, busy}, 32'd0);
        tick();

        // read with three wait states
        PREADY = 1'b0; PRDATA = 8'hA5;
        push(1'b0, 8'h60, 8'h11, 8'hA5, 1'b0, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rd_penable_stable", {31'd0, PENABLE}, 32'd1);
            chk("rd_psel_stable", {31'd0, PSELx}, 32'd1);
            chk("rd_paddr_stable", {24'd0, PADDR}, 32'h60);
            chk("rd_pwrite_stable", {31'd0, PWRITE}, 32'd0);
            chk("rd_no_rsp", {31'd0, rsp_valid}, 32'd0);
            if (i == 3) PREADY = 1'b1;
            else tick();
        end
        tick();
        chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_rsp_rdata", {24'd0, rsp_rdata}, 32'hA5);
        drain("rd_drain");

        // programming burst, back to back
        r0 = rsp_seen; f0 = psel_falls;
        push(1'b1, 8'h20, 8'h04, 8'h00, 1'b0, 1'b1);
        push(1'b1, 8'h40, 8'h01, 8'h00, 1'b0, 1'b1);
        push(1'b1, 8'h80, 8'h01, 8'h00, 1'b0, 1'b1);
        push(1'b1, 8'hC0, 8'h80, 8'h00, 1'b0, 1'b1);
        drain("burst_drain");
        chk("burst_rsp_count", rsp_seen - r0, 32'd4);
        chk("burst_psel_continuous", psel_falls - f0, 32'd1);

        // FIFO full while the slave stalls
        r0 = rsp_seen;
        PREADY = 1'b0; PRDATA = 8'h3C;
        push(1'b1, 8'h20, 8'h01, 8'h00, 1'b0, 1'b1);
        push(1'b0, 8'h40, 8'h00, 8'h3C, 1'b0, 1'b1);
        push(1'b1, 8'h60, 8'h03, 8'h00, 1'b0, 1'b1);
        push(1'b1, 8'h80, 8'h04, 8'h00, 1'b0, 1'b1);
        push(1'b1, 8'hC0, 8'h05, 8'h00, 1'b0, 1'b1);
        push(1'b1, 8'h22, 8'h06, 8'h00, 1'b0, 1'b0);
        PREADY = 1'b1;
        drain("full_drain");
        chk("full_rsp_count", rsp_seen - r0, 32'd5);

        // timeout abort, then a normal command
        PREADY = 1'b0;
        push(1'b0, 8'hC0, 8'h00, 8'h00, 1'b1, 1'b1);
        repeat (17) tick();
        chk("to_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        chk("to_psel_held", {31'd1 & 31'd0, PSELx}, 32'd1);
        tick();
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("to_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("to_psel_drop", {31'd0, PSELx}, 32'd0);
        PREADY = 1'b1;
        tick();
        push(1'b1, 8'h40, 8'h01, 8'h00, 1'b0, 1'b1);
        drain("to_drain");

        // reset mid-ACCESS with two commands queued
        PREADY = 1'b0;
        push(1'b1, 8'h20, 8'h07, 8'h00, 1'b0, 1'b1);
        push(1'b1, 8'h80, 8'h08, 8'h00, 1'b0, 1'b1);
        push(1'b1, 8'hC0, 8'h09, 8'h00, 1'b0, 1'b1);
        chk("mid_in_access", {31'd0, PENABLE}, 32'd1);
        #2;
        PRESETn = 1'b0;
        sb.delete();
        r0 = rsp_seen;
        #1;
        chk("mrst_psel", {31'd0, PSELx}, 32'd0);
        chk("mrst_penable", {31'd0, PENABLE}, 32'd0);
        chk("mrst_pwrite", {31'd0, PWRITE}, 32'd0);
        chk("mrst_paddr", {24'd0, PADDR}, 32'd0);
        chk("mrst_pwdata", {24'd0, PWDATA}, 32'd0);
        chk("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        tick();
        PRESETn = 1'b1;
        PREADY = 1'b1;
        repeat (8) tick();
        chk("mrst_no_rsp", rsp_seen - r0, 32'd0);
        chk("mrst_busy_after", {31'd0, busy}, 32'd0);
        chk("mrst_psel_after", {31'd0, PSELx}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
